elixirchip_es1_spu_op_reduce: RTL

Multi-channel, multi-mode bit-reduction operator for the ES1 SPU datapath, generalising the single-channel OR-reduce operator. Each of `CHANNELS` lanes reduces a `DATA_BITS`-wide word with ANY (OR), ALL (AND) or PARITY (XOR). The result can optionally be folded into a running per-lane accumulator. The result passes through a `LATENCY`-deep, clock-enabled, valid-gated pipeline, and it holds its value whenever no valid or clear reaches the output.

---
 rtl/elixirchip_es1_spu_op_reduce.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/elixirchip_es1_spu_op_reduce.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_reduce
//
// Multi-channel, multi-mode bit-reduction operator for the ES1 SPU datapath.
// Each of CHANNELS lanes reduces a DATA_BITS-wide word with ANY (OR),
// ALL (AND) or PARITY (XOR). The lane result either reloads a per-lane
// accumulator or is folded into it. The result then travels through a
// LATENCY-deep, clock-enabled, valid-gated pipeline. The output holds its
// value whenever no valid (or clear) reaches the last stage.
//
// Parameters:
//   LATENCY    pipeline depth in cke-qualified cycles (0 = combinational)
//   DATA_BITS  bits per channel word
//   CHANNELS   number of independent lanes
//   CLEAR_DATA value loaded into every lane by s_clear
//   DEVICE, SIMULATION, DEBUG  build-information strings (no effect on logic)
//
// Ports:
//   reset    in   synchronous reset, active-high (priority over cke)
//   clk      in   clock
//   cke      in   clock enable; 0 freezes every register
//   s_data   in   CHANNELS*DATA_BITS; lane i is bits [i*DATA_BITS +: DATA_BITS]
//   s_mode   in   0=ANY, 1=ALL, 2=PARITY, 3=illegal (result 0)
//   s_accum  in   fold the lane result into the accumulator instead of reloading
//   s_clear  in   load CLEAR_DATA into every lane (wins over s_valid)
//   s_valid  in   input valid
//   m_data   out  CHANNELS per-lane results
//
// Handshake: s_valid is a plain qualifier sampled on each cke-qualified edge;
// there is no ready/backpressure, so one beat is accepted per qualified cycle.
//
// Optional build macro:
//   ELIXIRCHIP_ES1_SPU_OP_REDUCE_ASSERT_EN
//     When defined, simulation checks flag s_mode=3 with s_valid, m_data
//     changing without an output valid, and s_accum used with LATENCY=0.
//     Each failure calls $error and then $finish(1). Without the macro no
//     check logic exists and the datapath is identical.
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_reduce #(
    parameter int   LATENCY    = 1,
    parameter int   DATA_BITS  = 8,
    parameter int   CHANNELS   = 1,
    parameter logic CLEAR_DATA = 1'b0,
    parameter       DEVICE     = "RTL",
    parameter       SIMULATION = "false",
    parameter       DEBUG      = "false"
) (
    input  logic                            reset,
    input  logic                            clk,
    input  logic                            cke,
    input  logic [CHANNELS*DATA_BITS-1:0]   s_data,
    input  logic [1:0]                      s_mode,
    input  logic                            s_accum,
    input  logic                            s_clear,
    input  logic                            s_valid,
    output logic [CHANNELS-1:0]             m_data
);

    localparam logic [1:0] MODE_ANY    = 2'd0;
    localparam logic [1:0] MODE_ALL    = 2'd1;
    localparam logic [1:0] MODE_PARITY = 2'd2;

    // Per-lane reduction of the incoming words.
    logic [CHANNELS-1:0] w_red;

    // High when the last stage holds a freshly delivered result.
    logic                w_out_valid;

    always_comb begin
        w_red = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (s_mode)
                MODE_ANY:    w_red[i] = |s_data[i*DATA_BITS +: DATA_BITS];
                MODE_ALL:    w_red[i] = &s_data[i*DATA_BITS +: DATA_BITS];
                MODE_PARITY: w_red[i] = ^s_data[i*DATA_BITS +: DATA_BITS];
                default:     w_red[i] = 1'b0;
            endcase
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            // Purely combinational: control inputs have no effect.
            logic w_unused_ctl;

            assign m_data       = w_red;
            assign w_out_valid  = 1'b1;
            assign w_unused_ctl = ^{reset, clk, cke, s_accum, s_clear, s_valid};
        end else begin : g_pipe
            // r_data[0] is the per-lane accumulator (stage 1);
            // r_data[LATENCY-1] drives m_data.
            logic [CHANNELS-1:0] r_data [LATENCY];
            logic [LATENCY-1:0]  r_vld;
            logic [CHANNELS-1:0] w_fold;
            logic [CHANNELS-1:0] w_clear;

            assign w_clear = {CHANNELS{CLEAR_DATA}};

            // Accumulate path: the operator follows the current s_mode,
            // so a chain may even switch operators beat by beat.
            always_comb begin
                w_fold = '0;
                case (s_mode)
                    MODE_ANY:    w_fold = r_data[0] | w_red;
                    MODE_ALL:    w_fold = r_data[0] & w_red;
                    MODE_PARITY: w_fold = r_data[0] ^ w_red;
                    default:     w_fold = '0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        r_data[k] <= '0;
                    end
                    r_vld <= '0;
                end else if (cke) begin
                    // Stage 1: clear beats valid; accumulator holds when idle.
                    if (s_clear) begin
                        r_data[0] <= w_clear;
                        r_vld[0]  <= 1'b1;
                    end else if (s_valid) begin
                        r_data[0] <= s_accum ? w_fold : w_red;
                        r_vld[0]  <= 1'b1;
                    end else begin
                        r_vld[0]  <= 1'b0;
                    end

                    // Later stages only capture when the stage before them
                    // carries a valid result, so the output holds between
                    // results instead of draining to stale data.
                    for (int k = 1; k < LATENCY; k++) begin
                        if (r_vld[k-1]) begin
                            r_data[k] <= r_data[k-1];
                        end
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            assign m_data      = r_data[LATENCY-1];
            assign w_out_valid = r_vld[LATENCY-1];
        end
    endgenerate

    // Build-information parameters and the output-valid flag are carried for
    // integration and the optional checks; they do not steer the datapath.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{w_out_valid,
                            (DEVICE == "RTL"),
                            (SIMULATION == "true"),
                            (DEBUG == "true")};

`ifdef ELIXIRCHIP_ES1_SPU_OP_REDUCE_ASSERT_EN
    // Snapshot of m_data after the previous edge, plus whether that edge was
    // a normal (non-reset) edge, so a change can be attributed to one edge.
    logic [CHANNELS-1:0] r_chk_m;
    logic                r_chk_armed;

    always_ff @(posedge clk) begin
        r_chk_m     <= m_data;
        r_chk_armed <= !reset;
    end

    always @(posedge clk) begin
        if (!reset && cke) begin
            if (s_valid && (s_mode == 2'd3)) begin
                $error("elixirchip_es1_spu_op_reduce: s_mode=3 with s_valid");
                $finish(1);
            end
            if ((LATENCY == 0) && s_accum) begin
                $error("elixirchip_es1_spu_op_reduce: s_accum with LATENCY=0");
                $finish(1);
            end
        end
        if ((LATENCY > 0) && !reset && (r_chk_armed === 1'b1) &&
            (m_data !== r_chk_m) && !w_out_valid) begin
            $error("elixirchip_es1_spu_op_reduce: m_data changed without output valid");
            $finish(1);
        end
    end
`endif

endmodule
